dds_bank_sum: RTL and testbench

//   N-channel DDS tone bank with a pipelined, saturating adder tree; parametrised successor to the

---
 rtl/dds_bank_sum.sv | 210 +++++++++++++++++++++
 tb/tb_dds_bank_sum.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_bank_sum.sv
// dds_bank_sum: NUM_CH-channel DDS tone bank summed through a pipelined saturating adder tree.
// Config writes land in shadow registers and are applied to all channels together on commit.
module dds_bank_sum #(
    parameter int NUM_CH  = 8,
    parameter int PHASE_W = 16,
    parameter int AMP_W   = 16,
    parameter int LUT_AW  = 10,
    parameter int OUT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [1:0]                cfg_sel,
    input  logic [PHASE_W-1:0]        cfg_data,
    input  logic                      cfg_commit,
    input  logic                      cfg_sync,
    output logic [OUT_W-1:0]          sample_out,
    output logic                      out_valid,
    output logic                      sat_flag
);

    localparam int LOG2    = $clog2(NUM_CH);
    localparam int LATENCY = 5 + LOG2;
    localparam int LUT_N   = 1 << LUT_AW;
    localparam int PROD_W  = 16 + AMP_W;
    localparam int TW      = AMP_W + LOG2;
    localparam int SH      = (AMP_W > OUT_W) ? (AMP_W - OUT_W) : 0;
    localparam int CW      = ((TW > OUT_W) ? TW : OUT_W) + 1;

    localparam logic signed [PROD_W-1:0] AMP_MAX = PROD_W'((64'sd1 <<< (AMP_W - 1)) - 64'sd1);
    localparam logic signed [PROD_W-1:0] AMP_MIN = PROD_W'(-(64'sd1 <<< (AMP_W - 1)));
    localparam logic signed [CW-1:0]     OUT_MAX = CW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [CW-1:0]     OUT_MIN = CW'(-(64'sd1 <<< (OUT_W - 1)));

    localparam longint PI_Q28 = 64'sd843314857;

    // round(32767*sin(2*pi*k/LUT_N)): quarter-wave symmetry plus a Q28 Taylor series,
    // so the table is built at elaboration without an external image.
    function automatic logic signed [15:0] sine_entry(input int k);
        longint quarter, q, j, x, x2, term, s, r;
        quarter = longint'(LUT_N / 4);
        q       = longint'(k) / quarter;
        j       = longint'(k) % quarter;
        if (q == 64'sd1 || q == 64'sd3) j = quarter - j;
        x    = (64'sd2 * PI_Q28 * j) / longint'(LUT_N);
        x2   = (x * x) >>> 28;
        s    = x;
        term = x;
        for (int m = 1; m <= 7; m++) begin
            term = -((term * x2) >>> 28) / longint'((2 * m) * (2 * m + 1));
            s    = s + term;
        end
        r = (s * 64'sd32767 + (64'sd1 <<< 27)) >>> 28;
        if (q >= 64'sd2) r = -r;
        return 16'(r);
    endfunction

    logic signed [15:0] lut [LUT_N];

    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        localparam logic signed [15:0] ENTRY = sine_entry(k);
        assign lut[k] = ENTRY;
    end

    logic signed [AMP_W-1:0] sh_amp [NUM_CH];
    logic signed [AMP_W-1:0] amp    [NUM_CH];
    logic [PHASE_W-1:0]      sh_off [NUM_CH];
    logic [PHASE_W-1:0]      off    [NUM_CH];
    logic [PHASE_W-1:0]      sh_pw  [NUM_CH];
    logic [PHASE_W-1:0]      pw     [NUM_CH];
    logic [NUM_CH-1:0]       sh_en;
    logic [NUM_CH-1:0]       ch_en;
    logic                    sync_acc;

    assign sync_acc = cfg_commit & cfg_sync;

    // Shadow write and commit on the same edge: commit copies the pre-write shadow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_amp[i] <= '0;
                amp[i]    <= '0;
                sh_off[i] <= '0;
                off[i]    <= '0;
                sh_pw[i]  <= '0;
                pw[i]     <= '0;
            end
            sh_en <= '0;
            ch_en <= '0;
        end else begin
            if (cfg_we) begin
                case (cfg_sel)
                    2'd0:    sh_amp[cfg_ch] <= AMP_W'(cfg_data);
                    2'd1:    sh_off[cfg_ch] <= cfg_data;
                    2'd2:    sh_pw[cfg_ch]  <= cfg_data;
                    default: sh_en[cfg_ch]  <= cfg_data[0];
                endcase
            end
            if (cfg_commit) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    amp[i] <= sh_amp[i];
                    off[i] <= sh_off[i];
                    pw[i]  <= sh_pw[i];
                end
                ch_en <= sh_en;
            end
        end
    end

    logic [PHASE_W-1:0]  acc   [NUM_CH];
    logic [LUT_AW-1:0]   addr  [NUM_CH];
    logic signed [15:0]  sin_q [NUM_CH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]   <= '0;
                addr[i]  <= '0;
                sin_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_acc)
                    acc[i] <= '0;
                else if (en)
                    acc[i] <= acc[i] + pw[i];
                addr[i]  <= LUT_AW'((acc[i] + off[i]) >> (PHASE_W - LUT_AW));
                sin_q[i] <= lut[addr[i]];
            end
        end
    end

    logic signed [PROD_W-1:0] prod_full [NUM_CH];
    logic signed [PROD_W-1:0] prod_sh   [NUM_CH];
    logic signed [AMP_W-1:0]  prod_d    [NUM_CH];
    logic                     sat_d;

    always_comb begin
        sat_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            prod_full[i] = PROD_W'(sin_q[i]) * PROD_W'(amp[i]);
            prod_sh[i]   = prod_full[i] >>> 15;
            if (!ch_en[i]) begin
                prod_d[i] = '0;
            end else if (prod_sh[i] > AMP_MAX) begin
                prod_d[i] = AMP_MAX[AMP_W-1:0];
                sat_d     = 1'b1;
            end else if (prod_sh[i] < AMP_MIN) begin
                prod_d[i] = AMP_MIN[AMP_W-1:0];
                sat_d     = 1'b1;
            end else begin
                prod_d[i] = prod_sh[i][AMP_W-1:0];
            end
        end
    end

    logic signed [AMP_W-1:0] prod_q [NUM_CH];
    logic signed [TW-1:0]    sum_q  [LOG2][NUM_CH];
    logic signed [CW-1:0]    root_sh;
    logic signed [OUT_W-1:0] out_d;
    logic signed [OUT_W-1:0] out_q;
    logic                    sat_o;
    logic [LATENCY-1:0]      vld;

    always_comb begin
        sat_o   = 1'b0;
        root_sh = CW'(sum_q[LOG2-1][0]) >>> SH;
        if (root_sh > OUT_MAX) begin
            out_d = OUT_MAX[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (root_sh < OUT_MIN) begin
            out_d = OUT_MIN[OUT_W-1:0];
            sat_o = 1'b1;
        end else begin
            out_d = root_sh[OUT_W-1:0];
        end
    end

    // Tree levels are full width; entries past each level's live count are held at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) prod_q[i] <= '0;
            for (int l = 0; l < LOG2; l++)
                for (int j = 0; j < NUM_CH; j++) sum_q[l][j] <= '0;
            out_q    <= '0;
            vld      <= '0;
            sat_flag <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) prod_q[i] <= prod_d[i];
            for (int j = 0; j < NUM_CH / 2; j++)
                sum_q[0][j] <= TW'(prod_q[2 * j]) + TW'(prod_q[2 * j + 1]);
            for (int j = NUM_CH / 2; j < NUM_CH; j++) sum_q[0][j] <= '0;
            for (int l = 1; l < LOG2; l++) begin
                for (int j = 0; j < NUM_CH / 2; j++)
                    sum_q[l][j] <= (j < (NUM_CH >> (l + 1))) ?
                                   sum_q[l-1][2 * j] + sum_q[l-1][2 * j + 1] : '0;
                for (int j = NUM_CH / 2; j < NUM_CH; j++) sum_q[l][j] <= '0;
            end
            out_q    <= out_d;
            vld      <= {vld[LATENCY-2:0], en};
            sat_flag <= sat_flag | sat_d | sat_o;
        end
    end

    assign sample_out = out_q;
    assign out_valid  = vld[LATENCY-1];

endmodule

// File: tb/tb_dds_bank_sum.sv
// Directed bench for dds_bank_sum (NUM_CH=8, LATENCY=8) with hand-computed expected samples.
module tb_dds_bank_sum;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic               cfg_we;
    logic [2:0]         cfg_ch;
    logic [1:0]         cfg_sel;
    logic [15:0]        cfg_data;
    logic               cfg_commit;
    logic               cfg_sync;
    logic signed [15:0] sample_out;
    logic               out_valid;
    logic               sat_flag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dds_bank_sum dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_sync   (cfg_sync),
        .sample_out (sample_out),
        .out_valid  (out_valid),
        .sat_flag   (sat_flag)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int ch, input int sel, input int data);
        cfg_ch   = 3'(ch);
        cfg_sel  = 2'(sel);
        cfg_data = 16'(data);
        cfg_we   = 1'b1;
        tick(1);
        cfg_we   = 1'b0;
    endtask

    task automatic commit(input logic sync);
        cfg_commit = 1'b1;
        cfg_sync   = sync;
        tick(1);
        cfg_commit = 1'b0;
        cfg_sync   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0;
        cfg_data = '0; cfg_commit = 1'b0; cfg_sync = 1'b0;
        #2 reset = 1'b0;
        #10;
        checks++;
        if (sample_out !== 16'sd0) begin
            failures++; $display("FAIL reset_sample got=%0d want=0", sample_out);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        checks++;
        if (sat_flag !== 1'b0) begin
            failures++; $display("FAIL reset_sat got=%b want=0", sat_flag);
        end
        @(negedge clk) reset = 1'b1;
        tick(10);
        checks++;
        if (out_valid !== 1'b0 || sample_out !== 16'sd0) begin
            failures++;
            $display("FAIL idle_no_en got valid=%b sample=%0d want valid=0 sample=0", out_valid, sample_out);
        end
    endtask

    task automatic test_single_channel();
        cfg_write(0, 0, 'h7FFF);
        cfg_write(0, 1, 'h4000);
        cfg_write(0, 2, 0);
        cfg_write(0, 3, 1);
        commit(1'b0);
        tick(10);
        en = 1'b1;
        tick(7);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL latency_early_valid got=%b want=0", out_valid);
        end
        tick(1);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL latency_valid got=%b want=1", out_valid);
        end
        checks++;
        if (sample_out !== 16'sd32766) begin
            failures++; $display("FAIL single_ch_sample got=%0d want=32766", sample_out);
        end
        checks++;
        if (sat_flag !== 1'b0) begin
            failures++; $display("FAIL single_ch_sat got=%b want=0", sat_flag);
        end
        tick(5);
        checks++;
        if (sample_out !== 16'sd32766) begin
            failures++; $display("FAIL single_ch_constant got=%0d want=32766", sample_out);
        end
    endtask

    task automatic test_saturation();
        for (int ch = 1; ch < 8; ch++) begin
            cfg_write(ch, 0, 'h7FFF);
            cfg_write(ch, 1, 'h4000);
            cfg_write(ch, 2, 0);
            cfg_write(ch, 3, 1);
        end
        checks++;
        if (sample_out !== 16'sd32766 || sat_flag !== 1'b0) begin
            failures++;
            $display("FAIL shadow_isolation got sample=%0d sat=%b want sample=32766 sat=0", sample_out, sat_flag);
        end
        commit(1'b0);
        tick(10);
        checks++;
        if (sample_out !== 16'sd32767) begin
            failures++; $display("FAIL sum_clamp got=%0d want=32767", sample_out);
        end
        checks++;
        if (sat_flag !== 1'b1) begin
            failures++; $display("FAIL sum_clamp_sat got=%b want=1", sat_flag);
        end
    endtask

    task automatic test_phase_sweep();
        int exp_seq [8];
        exp_seq = '{0, 32766, 0, -32767, 0, 32766, 0, -32767};
        for (int ch = 1; ch < 8; ch++) cfg_write(ch, 3, 0);
        cfg_write(0, 1, 0);
        cfg_write(0, 2, 'h4000);
        commit(1'b1);
        tick(7);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (sample_out !== 16'(exp_seq[i]) || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL sweep_%0d got sample=%0d valid=%b want sample=%0d valid=1",
                         i, sample_out, out_valid, exp_seq[i]);
            end
            tick(1);
        end
        checks++;
        if (sat_flag !== 1'b1) begin
            failures++; $display("FAIL sat_sticky got=%b want=1", sat_flag);
        end
    endtask

    task automatic test_commit_timing();
        cfg_write(0, 1, 'h4000);
        cfg_write(0, 2, 0);
        commit(1'b1);
        tick(10);
        checks++;
        if (sample_out !== 16'sd32766) begin
            failures++; $display("FAIL hold_setup got=%0d want=32766", sample_out);
        end
        cfg_write(0, 0, 'h2000);
        tick(8);
        checks++;
        if (sample_out !== 16'sd32766) begin
            failures++; $display("FAIL shadow_only got=%0d want=32766", sample_out);
        end
        cfg_ch = 3'd0; cfg_sel = 2'd0; cfg_data = 16'h1000;
        cfg_we = 1'b1; cfg_commit = 1'b1;
        tick(1);
        cfg_we = 1'b0; cfg_commit = 1'b0;
        tick(4);
        checks++;
        if (sample_out !== 16'sd32766) begin
            failures++; $display("FAIL commit_edge5 got=%0d want=32766", sample_out);
        end
        tick(1);
        checks++;
        if (sample_out !== 16'sd8191) begin
            failures++; $display("FAIL commit_edge6 got=%0d want=8191", sample_out);
        end
        tick(3);
        commit(1'b0);
        tick(5);
        checks++;
        if (sample_out !== 16'sd4095) begin
            failures++; $display("FAIL we_commit_overlap got=%0d want=4095", sample_out);
        end
    endtask

    task automatic test_sync_hold();
        cfg_write(0, 0, 'h7FFF);
        cfg_write(0, 1, 'h4000);
        cfg_write(0, 2, 'h1234);
        commit(1'b0);
        tick(10);
        en = 1'b0;
        commit(1'b1);
        tick(2);
        en = 1'b1;
        tick(4);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL sync_pre_valid got=%b want=1", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (out_valid !== 1'b0 || sample_out !== 16'sd32766) begin
                failures++;
                $display("FAIL sync_hold_%0d got valid=%b sample=%0d want valid=0 sample=32766",
                         i, out_valid, sample_out);
            end
        end
        tick(1);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL sync_post_valid got=%b want=1", out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        checks++;
        if (sat_flag !== 1'b1) begin
            failures++; $display("FAIL pre_reset_sat got=%b want=1", sat_flag);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (sample_out !== 16'sd0 || out_valid !== 1'b0 || sat_flag !== 1'b0) begin
            failures++;
            $display("FAIL async_clear got sample=%0d valid=%b sat=%b want 0/0/0", sample_out, out_valid, sat_flag);
        end
        tick(2);
        @(negedge clk) reset = 1'b1;
        tick(7);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL restart_early_valid got=%b want=0", out_valid);
        end
        tick(1);
        checks++;
        if (out_valid !== 1'b1 || sample_out !== 16'sd0) begin
            failures++;
            $display("FAIL config_lost got valid=%b sample=%0d want valid=1 sample=0", out_valid, sample_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_saturation();
        test_phase_sweep();
        test_commit_timing();
        test_sync_hold();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
